// File: rtl/cnot_engine.sv
// Sequential CNOT engine: holds the full 2^NUM_QUBITS Q16.16 state vector and applies
// CNOT(ctrl,tgt) by walking every index once, plus streaming load and readout ports.
module cnot_engine #(
  parameter int NUM_QUBITS = 3,
  parameter int AMP_W      = 32,
  parameter int FRAC_W     = 16,
  localparam int DEPTH     = 2 ** NUM_QUBITS,
  localparam int IDX_W     = (NUM_QUBITS > 1) ? $clog2(NUM_QUBITS) : 1,
  localparam int PTR_W     = NUM_QUBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [AMP_W-1:0] load_data,
  input  logic             start,
  input  logic [IDX_W-1:0] ctrl_idx,
  input  logic [IDX_W-1:0] tgt_idx,
  input  logic             dump,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [AMP_W-1:0] rd_data,
  output logic             rd_last
);

  typedef enum logic [1:0] {IDLE, APPLY, REJECT, DUMP} state_t;

  localparam logic [AMP_W-1:0] ONE_AMP  = AMP_W'(1) << FRAC_W;
  localparam logic [PTR_W-1:0] LAST_PTR = {PTR_W{1'b1}};
  localparam logic [IDX_W:0]   NQ       = (IDX_W + 1)'(NUM_QUBITS);

  state_t           state_reg;
  logic [AMP_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] scan_reg;
  logic [IDX_W-1:0] ctrl_reg;
  logic [IDX_W-1:0] tgt_reg;
  logic             done_reg;
  logic             err_reg;

  logic             illegal_pair;
  logic [PTR_W-1:0] tgt_mask;
  logic [PTR_W-1:0] partner;
  logic             do_swap;

  assign illegal_pair = (ctrl_idx == tgt_idx) ||
                        ({1'b0, ctrl_idx} >= NQ) ||
                        ({1'b0, tgt_idx} >= NQ);

  // Only the ctrl=1/tgt=0 half of each pair initiates the swap, so each pair swaps once.
  assign tgt_mask = PTR_W'(1) << tgt_reg;
  assign partner  = scan_reg ^ tgt_mask;
  assign do_swap  = scan_reg[ctrl_reg] && !scan_reg[tgt_reg];

  assign load_ready = (state_reg == IDLE) && !start && !dump;
  assign busy       = (state_reg == APPLY) || (state_reg == DUMP);
  assign done       = done_reg;
  assign err        = err_reg;
  assign rd_valid   = (state_reg == DUMP);
  assign rd_data    = mem[rd_ptr_reg];
  assign rd_last    = (state_reg == DUMP) && (rd_ptr_reg == LAST_PTR);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= (i == 0) ? ONE_AMP : '0;
      end
      state_reg  <= IDLE;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      scan_reg   <= '0;
      ctrl_reg   <= '0;
      tgt_reg    <= '0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            wr_ptr_reg <= '0;
            if (illegal_pair) begin
              err_reg   <= 1'b1;
              done_reg  <= 1'b1;
              state_reg <= REJECT;
            end else begin
              ctrl_reg  <= ctrl_idx;
              tgt_reg   <= tgt_idx;
              err_reg   <= 1'b0;
              scan_reg  <= '0;
              state_reg <= APPLY;
            end
          end else if (dump) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            state_reg  <= DUMP;
          end else if (load_valid) begin
            mem[wr_ptr_reg] <= load_data;
            wr_ptr_reg      <= wr_ptr_reg + 1'b1;
          end
        end
        APPLY: begin
          if (do_swap) begin
            mem[scan_reg] <= mem[partner];
            mem[partner]  <= mem[scan_reg];
          end
          if (scan_reg == LAST_PTR) begin
            done_reg  <= 1'b1;
            state_reg <= IDLE;
          end else begin
            scan_reg <= scan_reg + 1'b1;
          end
        end
        REJECT: begin
          state_reg <= IDLE;
        end
        DUMP: begin
          if (rd_ready) begin
            if (rd_ptr_reg == LAST_PTR) begin
              rd_ptr_reg <= '0;
              state_reg  <= IDLE;
            end else begin
              rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnot_engine.sv
// Directed bench for cnot_engine (3 qubits): vector table of load/CNOT/dump cases plus
// hand-written reset, involution, partial-load and backpressure sequences.
module tb_cnot_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic        start;
  logic [1:0]  ctrl_idx;
  logic [1:0]  tgt_idx;
  logic        dump;
  logic        busy;
  logic        done;
  logic        err;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic        rd_last;

  int n_checks = 0;
  int n_fail   = 0;

  cnot_engine #(.NUM_QUBITS(3), .AMP_W(32), .FRAC_W(16)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .start(start), .ctrl_idx(ctrl_idx), .tgt_idx(tgt_idx), .dump(dump),
    .busy(busy), .done(done), .err(err),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last)
  );

  always #5 clk = ~clk;

  typedef logic [7:0][31:0] vecarr_t;

  typedef struct packed {
    logic [1:0] ctrl;
    logic [1:0] tgt;
    logic       exp_err;
    vecarr_t    init;
    vecarr_t    exp;
  } vec_t;

  localparam int NVEC = 8;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Each nibble k of p names the source index for element k.
  function automatic vecarr_t permute(input vecarr_t v, input logic [31:0] p);
    vecarr_t r;
    for (int k = 0; k < 8; k++) r[k] = v[int'(p[4*k +: 4])];
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    load_valid = 1'b0; load_data = '0; start = 1'b0; dump = 1'b0;
    ctrl_idx = '0; tgt_idx = '0; rd_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic load_n(input vecarr_t v, input int n);
    for (int k = 0; k < n; k++) begin
      load_valid = 1'b1;
      load_data  = v[k];
      #1;
      chk("load_ready", 32'(load_ready), 32'd1);
      tick();
    end
    load_valid = 1'b0;
  endtask

  task automatic run_start(input logic [1:0] c, input logic [1:0] t, input bit legal, output int lat);
    start = 1'b1; ctrl_idx = c; tgt_idx = t;
    tick();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      chk("busy_apply", 32'(busy), 32'(legal));
      tick();
      lat++;
    end
    chk("busy_at_done", 32'(busy), 32'd0);
    tick();
    chk("done_pulse_width", 32'(done), 32'd0);
  endtask

  task automatic dump_all(input bit rnd, output vecarr_t got);
    int beats, cyc;
    bit held;
    logic [31:0] prev_data;
    logic prev_last;
    got = '0; beats = 0; cyc = 0; held = 1'b0; prev_data = '0; prev_last = 1'b0;
    dump = 1'b1;
    tick();
    dump = 1'b0;
    while (beats < 8 && cyc < 200) begin
      if (held) begin
        chk("rd_data_hold", rd_data, prev_data);
        chk("rd_last_hold", 32'(rd_last), 32'(prev_last));
      end
      rd_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      held      = rd_valid && !rd_ready;
      prev_data = rd_data;
      prev_last = rd_last;
      if (rd_valid && rd_ready) begin
        got[beats] = rd_data;
        chk("rd_last", 32'(rd_last), 32'(beats == 7));
        beats++;
      end
      tick();
      cyc++;
    end
    rd_ready = 1'b0;
    chk("dump_beats", 32'(beats), 32'd8);
    chk("dump_idle", 32'(rd_valid), 32'd0);
  endtask

  task automatic cmp_vec(input string name, input vecarr_t got, input vecarr_t exp);
    for (int k = 0; k < 8; k++) chk(name, got[k], exp[k]);
  endtask

  initial begin
    vecarr_t a, z, ground, got;
    int lat, done_seen;

    a[0] = 32'h0001_1111; a[1] = 32'h0002_2222; a[2] = 32'hFFFF_4AFB; a[3] = 32'h0004_4444;
    a[4] = 32'h8000_0000; a[5] = 32'h7FFF_FFFF; a[6] = 32'h0000_B505; a[7] = 32'h1234_5678;
    z = '0;
    ground = '0; ground[0] = 32'h0001_0000;

    vecs[0] = '{ctrl: 2'd2, tgt: 2'd0, exp_err: 1'b0, init: z, exp: z};
    vecs[0].init[4] = 32'h0001_0000;
    vecs[0].exp[5]  = 32'h0001_0000;
    vecs[1] = '{ctrl: 2'd0, tgt: 2'd1, exp_err: 1'b0, init: z, exp: z};
    vecs[1].init[0] = 32'h0000_B505; vecs[1].init[1] = 32'h0000_B505;
    vecs[1].exp[0]  = 32'h0000_B505; vecs[1].exp[3]  = 32'h0000_B505;
    vecs[2] = '{ctrl: 2'd0, tgt: 2'd2, exp_err: 1'b0, init: a, exp: permute(a, 32'h3614_7250)};
    vecs[3] = '{ctrl: 2'd1, tgt: 2'd1, exp_err: 1'b1, init: a, exp: a};
    vecs[4] = '{ctrl: 2'd3, tgt: 2'd0, exp_err: 1'b1, init: a, exp: a};
    vecs[5] = '{ctrl: 2'd2, tgt: 2'd1, exp_err: 1'b0, init: a, exp: permute(a, 32'h5476_3210)};
    vecs[6] = '{ctrl: 2'd1, tgt: 2'd2, exp_err: 1'b0, init: a, exp: permute(a, 32'h3254_7610)};
    vecs[7] = '{ctrl: 2'd0, tgt: 2'd3, exp_err: 1'b1, init: a, exp: a};

    do_reset();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_rd_last", 32'(rd_last), 32'd0);
    chk("reset_load_ready", 32'(load_ready), 32'd1);
    chk("reset_rd_data", rd_data, 32'h0001_0000);

    dump_all(1'b0, got);
    cmp_vec("reset_dump", got, ground);
    $display("reset dump: beat0=0x%08h beat7=0x%08h", got[0], got[7]);

    for (int i = 0; i < NVEC; i++) begin
      load_n(vecs[i].init, 8);
      run_start(vecs[i].ctrl, vecs[i].tgt, !vecs[i].exp_err, lat);
      chk("latency", 32'(lat), vecs[i].exp_err ? 32'd1 : 32'd9);
      chk("err_flag", 32'(err), 32'(vecs[i].exp_err));
      dump_all(1'b0, got);
      cmp_vec("vec_dump", got, vecs[i].exp);
      $display("vec %0d: ctrl=%0d tgt=%0d latency=%0d err=%0b", i, vecs[i].ctrl, vecs[i].tgt, lat, err);
    end

    load_n(a, 8);
    run_start(2'd0, 2'd2, 1'b1, lat);
    run_start(2'd0, 2'd2, 1'b1, lat);
    dump_all(1'b0, got);
    cmp_vec("involution", got, a);
    $display("involution: CNOT(0,2) twice, beat2=0x%08h", got[2]);

    load_n(a, 8);
    dump_all(1'b1, got);
    cmp_vec("backpressure_dump", got, a);
    $display("backpressure dump: beat7=0x%08h", got[7]);

    do_reset();
    load_n(a, 3);
    dump_all(1'b0, got);
    begin
      vecarr_t exp_partial;
      exp_partial = z;
      exp_partial[0] = a[0]; exp_partial[1] = a[1]; exp_partial[2] = a[2];
      cmp_vec("partial_load", got, exp_partial);
    end
    $display("partial load: 3 beats, beat3=0x%08h", got[3]);

    load_n(a, 8);
    start = 1'b1; ctrl_idx = 2'd0; tgt_idx = 2'd1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    rst = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (done) done_seen++;
      tick();
    end
    chk("abort_no_done", 32'(done_seen), 32'd0);
    dump_all(1'b0, got);
    cmp_vec("abort_dump", got, ground);
    $display("reset mid-apply: beat0=0x%08h", got[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
